// File: rtl/bcd_bin_conv_pkg.sv
// bcd_bin_conv_pkg: shared state encoding and BCD digit constants
package bcd_bin_conv_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/bcd_bin_conv_sub3.sv
// bcd_sub3_digit: one BCD digit correction (dig_i >= 8 ? dig_i - 3 : dig_i); ports dig_i in, dig_o out
module bcd_sub3_digit (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);
  assign dig_o = dig_i >= 4'd8 ? dig_i - 4'd3 : dig_i;
endmodule

// File: rtl/bcd_bin_conv.sv
// bcd_bin_conv: sequential BCD-to-binary (reverse double-dabble); clk/rst, start+bcd in, bin/busy/done/err/ovf out
module bcd_bin_conv
  import bcd_bin_conv_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BW = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [BW-1:0]               bin,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        ovf
);
  localparam int BCDW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BW + 1);
  state_e state_q;
  logic [BCDW-1:0] sr_bcd_q, sr_bcd_d, sh_bcd;
  logic [BW-1:0] sr_bin_q, sh_bin, bin_q;
  logic [CW-1:0] cnt_q;
  logic [DIGITS-1:0] bad;
  logic done_q, err_q, ovf_q;
  // 0 enters the BCD MSB; the binary LSB falls out
  assign {sh_bcd, sh_bin} = {1'b0, sr_bcd_q, sr_bin_q[BW-1:1]};
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    bcd_sub3_digit u_sub3 (
      .dig_i(sh_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dig_o(sr_bcd_d[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
    assign bad[d] = bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sr_bcd_q <= '0;
      sr_bin_q <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          sr_bcd_q <= bcd;
          sr_bin_q <= '0;
          cnt_q    <= '0;
          err_q    <= |bad;
          bin_q    <= '0;
          ovf_q    <= 1'b0;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          sr_bcd_q <= sr_bcd_d;
          sr_bin_q <= sh_bin;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(BW - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // any BCD left after BW shifts is value bits above BW
          bin_q   <= err_q ? '0 : sr_bin_q;
          ovf_q   <= !err_q && |sr_bcd_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bin  = bin_q;
  assign busy = state_q != ST_IDLE;
  assign done = done_q;
  assign err  = err_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_bcd_bin_conv.sv
// tb_bcd_bin_conv: directed self-checking bench for a 2-digit and a 3-digit converter
module tb_bcd_bin_conv;
  logic clk = 0, rst = 1;
  logic start_a = 0, start_b = 0;
  logic [7:0] bcd_a = 0;
  logic [11:0] bcd_b = 0;
  logic [6:0] bin_a, bin_b;
  logic busy_a, done_a, err_a, ovf_a, busy_b, done_b, err_b, ovf_b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  bcd_bin_conv #(.DIGITS(2), .BW(7)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bcd(bcd_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .err(err_a), .ovf(ovf_a)
  );
  bcd_bin_conv #(.DIGITS(3), .BW(7)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bcd(bcd_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .err(err_b), .ovf(ovf_b)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic dn(input bit s); return s ? done_b : done_a; endfunction
  function automatic logic bz(input bit s); return s ? busy_b : busy_a; endfunction
  // Called #1 after an edge; start is raised in the current cycle.
  task automatic conv(input bit s, input logic [11:0] v, input int eb, input int ee, input int eo, input string tag);
    int n, nb;
    if (s) begin start_b = 1; bcd_b = v; end else begin start_a = 1; bcd_a = v[7:0]; end
    @(posedge clk); #1;
    start_a = 0; start_b = 0;
    n = 1; nb = 0;
    while (!dn(s) && n < 20) begin
      nb += int'(bz(s));
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 9);
    check({tag, " busy cycles"}, nb, 8);
    check({tag, " bin"}, s ? bin_b : bin_a, eb);
    check({tag, " err"}, s ? err_b : err_a, ee);
    check({tag, " ovf"}, s ? ovf_b : ovf_a, eo);
    @(posedge clk); #1;
    check({tag, " done width"}, dn(s), 0);
    check({tag, " bin held"}, s ? bin_b : bin_a, eb);
  endtask
  initial begin
    int n, np;
    repeat (3) @(posedge clk);
    #1;
    check("reset a", {bin_a, busy_a, done_a, err_a, ovf_a}, 0);
    check("reset b", {bin_b, busy_b, done_b, err_b, ovf_b}, 0);
    rst = 0;
    @(posedge clk); #1;
    conv(0, 12'h099, 99, 0, 0, "a99");
    conv(0, 12'h000, 0, 0, 0, "a00");
    conv(0, 12'h015, 15, 0, 0, "a15");
    conv(0, 12'h007, 7, 0, 0, "a07");
    conv(0, 12'h01A, 0, 1, 0, "a1A");
    conv(0, 12'h042, 42, 0, 0, "a42");
    conv(1, 12'h127, 127, 0, 0, "b127");
    conv(1, 12'h128, 0, 0, 1, "b128");
    conv(1, 12'h999, 103, 0, 1, "b999");
    // extra starts during SHIFT and during the DONE state must be ignored
    start_a = 1; bcd_a = 8'h36;
    @(posedge clk); #1;
    start_a = 0;
    np = 0;
    for (n = 1; n < 20; n++) begin
      np += int'(done_a);
      if (n == 4 || n == 8) begin start_a = 1; bcd_a = 8'h99; end
      else start_a = 0;
      if (done_a) check("ign bin", bin_a, 36);
      @(posedge clk); #1;
    end
    start_a = 0;
    check("ign done count", np, 1);
    check("ign idle", busy_a, 0);
    // reset together with start mid-SHIFT aborts with no done pulse
    start_a = 1; bcd_a = 8'h25;
    @(posedge clk); #1;
    start_a = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; start_a = 1; bcd_a = 8'h77;
    @(posedge clk); #1;
    rst = 0; start_a = 0;
    check("rst outputs", {bin_a, busy_a, done_a, err_a, ovf_a}, 0);
    np = 0;
    repeat (12) begin
      @(posedge clk); #1;
      np += int'(done_a) + int'(busy_a);
    end
    check("rst no activity", np, 0);
    conv(0, 12'h063, 63, 0, 0, "a63");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
